// File: rtl/note_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : note_scheduler
// Description : Frame-rate chart sequencer for the rhythm game. Launches lane
//               droppers in timed order and accumulates score and combo.
//               Optional build macro COMBO_BONUS_EN: hits landing while the
//               combo is already >= 10 are worth 15 instead of 10.
// Revision    : 1.0 - initial release
// ============================================================================
module note_scheduler #(
  parameter int NUM_LANES   = 4,
  parameter int CHART_DEPTH = 16,
  parameter int GAP_W       = 8
) (
  input  logic                           frame_clk,
  input  logic                           Reset,
  input  logic [7:0]                     keycode,
  input  logic [7:0]                     keycode_second,
  input  logic                           wr_en,
  input  logic [$clog2(CHART_DEPTH)-1:0] wr_addr,
  input  logic [$clog2(NUM_LANES)-1:0]   wr_lane,
  input  logic [GAP_W-1:0]               wr_gap,
  input  logic [$clog2(CHART_DEPTH):0]   chart_len,
  input  logic [NUM_LANES-1:0]           lane_done,
  input  logic [NUM_LANES-1:0]           lane_hit,
  output logic [NUM_LANES-1:0]           launch,
  output logic [NUM_LANES-1:0]           lane_busy,
  output logic [15:0]                    score,
  output logic [7:0]                     combo,
  output logic                           song_done
);

  localparam int AW = $clog2(CHART_DEPTH);
  localparam int LW = $clog2(NUM_LANES);
  localparam int HW = $clog2(NUM_LANES + 1);
  localparam logic [7:0] KEY_START = 8'h2C;
  localparam logic [7:0] KEY_QUIT  = 8'h01;
  localparam logic [AW:0] LEN_ONE  = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_GAP = 3'd1,
    S_LAUNCH   = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [AW:0]          len_q, len_d;
  logic [NUM_LANES-1:0] launch_q, launch_d;
  logic [NUM_LANES-1:0] busy_q, busy_d;
  logic [15:0]          score_q, score_d;
  logic [7:0]           combo_q, combo_d;

  logic [LW-1:0]        chart_lane_q [CHART_DEPTH];
  logic [LW-1:0]        chart_lane_d [CHART_DEPTH];
  logic [GAP_W-1:0]     chart_gap_q  [CHART_DEPTH];
  logic [GAP_W-1:0]     chart_gap_d  [CHART_DEPTH];

  logic [NUM_LANES-1:0] valid_done;
  logic [NUM_LANES-1:0] valid_hit;
  logic [HW-1:0]        hit_cnt;
  logic                 any_miss;
  logic [17:0]          per_hit;
  logic [17:0]          score_sum;
  logic [8:0]           combo_sum;
  logic [15:0]          score_new;
  logic [7:0]           combo_new;
  logic                 results_on;
  logic                 start_key;
  logic                 quit_key;
  logic [LW-1:0]        cur_lane;
  logic [AW-1:0]        idx_next;

  assign start_key = (keycode == KEY_START) || (keycode_second == KEY_START);
  assign quit_key  = (keycode == KEY_QUIT)  || (keycode_second == KEY_QUIT);
  assign cur_lane  = chart_lane_q[idx_q];
  assign idx_next  = idx_q + 1'b1;

  // Dones on lanes with nothing in flight are discarded before scoring.
  always_comb begin
    valid_done = lane_done & busy_q;
    valid_hit  = valid_done & lane_hit;
    any_miss   = |(valid_done & ~lane_hit);
    hit_cnt    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      hit_cnt = hit_cnt + HW'(valid_hit[i]);
    end
`ifdef COMBO_BONUS_EN
    per_hit = (combo_q >= 8'd10) ? 18'd15 : 18'd10;
`else
    per_hit = 18'd10;
`endif
    score_sum = {2'b00, score_q} + (18'(hit_cnt) * per_hit);
    combo_sum = {1'b0, combo_q} + 9'(hit_cnt);
    score_new = (score_sum > 18'h0FFFF) ? 16'hFFFF : score_sum[15:0];
    combo_new = (combo_sum > 9'h0FF) ? 8'hFF : combo_sum[7:0];
    if (any_miss) begin
      combo_new = 8'h00;
    end
  end

  always_comb begin
    chart_lane_d = chart_lane_q;
    chart_gap_d  = chart_gap_q;
    if ((state_q == S_IDLE) && wr_en) begin
      chart_lane_d[wr_addr] = wr_lane;
      chart_gap_d[wr_addr]  = wr_gap;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_cnt_d  = gap_cnt_q;
    len_d      = len_q;
    launch_d   = '0;
    busy_d     = busy_q;
    score_d    = score_q;
    combo_d    = combo_q;
    results_on = (state_q == S_WAIT_GAP) || (state_q == S_LAUNCH) ||
                 (state_q == S_DRAIN);

    if (results_on) begin
      busy_d  = busy_q & ~valid_done;
      score_d = score_new;
      combo_d = combo_new;
    end

    case (state_q)
      S_IDLE: begin
        if (start_key) begin
          len_d   = chart_len;
          score_d = '0;
          combo_d = '0;
          busy_d  = '0;
          idx_d   = '0;
          if (chart_len == '0) begin
            state_d = S_DONE;
          end else begin
            gap_cnt_d = chart_gap_q[0];
            state_d   = S_WAIT_GAP;
          end
        end
      end
      S_WAIT_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_LAUNCH;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_LAUNCH: begin
        // A done on the target lane this cycle frees it for the relaunch.
        if (!(busy_q[cur_lane] && !lane_done[cur_lane])) begin
          launch_d[cur_lane] = 1'b1;
          busy_d[cur_lane]   = 1'b1;
          idx_d              = idx_next;
          if ({1'b0, idx_q} == (len_q - LEN_ONE)) begin
            state_d = S_DRAIN;
          end else begin
            gap_cnt_d = chart_gap_q[idx_next];
            state_d   = S_WAIT_GAP;
          end
        end
      end
      S_DRAIN: begin
        if (busy_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (quit_key) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      len_q     <= '0;
      launch_q  <= '0;
      busy_q    <= '0;
      score_q   <= '0;
      combo_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_cnt_q <= gap_cnt_d;
      len_q     <= len_d;
      launch_q  <= launch_d;
      busy_q    <= busy_d;
      score_q   <= score_d;
      combo_q   <= combo_d;
    end
  end

  // Chart storage deliberately has no reset so a loaded song survives Reset.
  always_ff @(posedge frame_clk) begin
    chart_lane_q <= chart_lane_d;
    chart_gap_q  <= chart_gap_d;
  end

  assign launch    = launch_q;
  assign lane_busy = busy_q;
  assign score     = score_q;
  assign combo     = combo_q;
  assign song_done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Chart sequencer that launches the per-lane arrow droppers of the rhythm game in timed order.
- Collects each dropper's hit/miss result and keeps the running score and combo.
- Sits between keyboard decode (keycode, keycode_second) and the lane droppers.
- Clocked by frame_clk, so one cycle equals one video frame.

Parameters:
- NUM_LANES, 4, number of dropper lanes driven.
- CHART_DEPTH, 16, number of chart entries (power of 2).
- GAP_W, 8, width of the per-entry inter-note frame gap.

Ports:
- frame_clk  in  1  frame clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  8  primary USB keycode.
- keycode_second  in  8  secondary USB keycode.
- wr_en  in  1  chart write strobe; honoured only in IDLE.
- wr_addr  in  $clog2(CHART_DEPTH)  chart entry index.
- wr_lane  in  $clog2(NUM_LANES)  lane for the entry.
- wr_gap  in  GAP_W  frames to wait before launching the entry.
- chart_len  in  $clog2(CHART_DEPTH)+1  number of valid entries; sampled on start.
- lane_done  in  NUM_LANES  one-cycle pulse per lane when its arrow is resolved.
- lane_hit  in  NUM_LANES  qualifies lane_done: 1 = hit, 0 = miss.
- launch  out  NUM_LANES  one-cycle launch pulse to the droppers.
- lane_busy  out  NUM_LANES  lane has an arrow in flight.
- score  out  16  accumulated score.
- combo  out  8  consecutive hits.
- song_done  out  1  high while in DONE.

Behaviour:
- Reset: state=IDLE, idx=0, gap_cnt=0, launch=0, lane_busy=0, score=0, combo=0, song_done=0.
- Chart: CHART_DEPTH x (lane, gap) registers. A write lands on the frame_clk edge when wr_en=1 in IDLE; writes in any other state are ignored. Chart contents survive Reset.
- IDLE:
  - Start when keycode==8'h2C or keycode_second==8'h2C.
  - On start: latch chart_len; clear score, combo and lane_busy; set idx=0.
  - If the latched chart_len==0, go to DONE. Otherwise load gap_cnt=gap[0] and go to WAIT_GAP.
- WAIT_GAP: if gap_cnt==0, go to LAUNCH next cycle; otherwise decrement. The launch pulse therefore comes gap+1 cycles after WAIT_GAP is entered.
- LAUNCH, with L=lane[idx]:
  - Stall while lane_busy[L] & ~lane_done[L]; launch stays 0.
  - Otherwise pulse launch[L] for exactly this cycle and set lane_busy[L]. A same-cycle done on L clears and re-sets it, so it stays 1.
  - Then idx++. If idx==chart_len-1 go to DRAIN; else load gap_cnt=gap[idx+1] and go to WAIT_GAP.
- DRAIN: when lane_busy==0 after this cycle's done clears, go to DONE.
- DONE: song_done=1. keycode==8'h01 (either key port) returns to IDLE; score and combo hold until the next start.
- Result handling: active in WAIT_GAP, LAUNCH and DRAIN; ignored in IDLE and DONE.
  - Every lane with lane_done=1 and lane_busy=1 clears its busy bit. A done on a non-busy lane is ignored entirely.
  - Several lanes resolving in one cycle: score += 10 x (number of hits); combo += number of hits.
  - If any valid done that cycle is a miss, combo=0 after applying that cycle's hits.
  - score saturates at 16'hFFFF; combo saturates at 8'hFF.
- Reset mid-song: immediate IDLE with all outputs at reset values; in-flight droppers are not notified.
- Latencies: all outputs are registered. A launch becomes visible the cycle after the LAUNCH decision.

Optional Feature:
- Macro: COMBO_BONUS_EN.
- Defined: each valid hit adds 15 instead of 10 when the combo value at the start of that cycle is >=10.
- Undefined: every hit adds 10.

Test Plan:
- Write 3 entries (lane0 gap2, lane1 gap0, lane2 gap1), chart_len=3, keycode=8'h2C -> launch 4'b0001 three cycles after WAIT_GAP entry, 4'b0010 two cycles later, 4'b0100 three cycles after that; state DRAIN.
- lane_done=4'b0101 with lane_hit=4'b0101 in one cycle on busy lanes 0 and 2 -> score +20, combo +2, lane_busy bits 0 and 2 clear.
- Two consecutive entries on lane 0 with lane 0 still busy -> launch held at 0 until lane_done[0]. A done and relaunch in the same cycle leave lane_busy[0]=1.
- Hit, hit, miss -> combo 1, 2, 0; score 20. In DONE, keycode_second=8'h01 -> IDLE with score still 20.
- chart_len=0 plus start -> DONE next cycle, no launch. Reset asserted during WAIT_GAP -> IDLE, score=0, lane_busy=0. wr_en during WAIT_GAP -> chart unchanged.
- With COMBO_BONUS_EN, 12 consecutive hits -> score = 10x10 + 2x15 = 130. Without the macro -> 120.
